// File: rtl/serial_add_scheduler_if.sv
// Request/response bundle between adder clients and serial_add_scheduler.
//   req     : per-requester request level
//   opa/opb : packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt     : one-hot grant, one cycle, when operands are captured
//   busy    : scheduler is between grant and done
//   done    : one-cycle pulse, result/done_id/cout valid
//   done_id : requester the result belongs to
//   result  : sum mod 2^WIDTH, held until next done
//   cout    : final carry (zero unless carry output is enabled)
// master = client side, slave = scheduler side.
interface serial_add_scheduler_if #(
  parameter int WIDTH = 23,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] opa;
  logic [NREQ*WIDTH-1:0] opb;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic [WIDTH-1:0]      result;
  logic                  cout;

  modport master (
    output req, opa, opb,
    input  gnt, busy, done, done_id, result, cout
  );

  modport slave (
    input  req, opa, opb,
    output gnt, busy, done, done_id, result, cout
  );
endinterface

// File: rtl/serial_add_scheduler.sv
// serial_add_scheduler: one bit-serial adder shared by NREQ requesters.
// A round-robin arbiter picks a pending request in IDLE and captures its
// operands; WIDTH shift/add cycles follow; DONE presents the sum for a cycle.
// Ports:
//   clk  : clock, posedge
//   rst  : synchronous active-high reset
//   bus  : serial_add_scheduler_if.slave (req/opa/opb in; gnt/busy/done/
//          done_id/result/cout out)
// Build option: define SERIAL_ADD_CARRY_EN to drive cout with the final
// carry of each add; otherwise cout is tied low.
module serial_add_scheduler #(
  parameter int WIDTH = 23,
  parameter int NREQ  = 4
) (
  input logic                  clk,
  input logic                  rst,
  serial_add_scheduler_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry;
  logic [CW-1:0]    count;
  logic [IDW-1:0]   last;
  logic [NREQ-1:0]  gnt_q;
  logic [IDW-1:0]   done_id_q;
  logic [WIDTH-1:0] result_q;

  // arbiter outputs
  logic             win_vld;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   cand;
  logic [WIDTH-1:0] opa_w, opb_w;

  // serial datapath
  logic [1:0]       sum;
  logic [WIDTH-1:0] a_nxt;
  logic             last_bit;

  // Round-robin: scan last+1, last+2, ... wrapping, first set req wins.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last) + k) % NREQ);
      if (!win_vld && bus.req[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
  end

  // Operand mux for the winner.
  always_comb begin
    opa_w = '0;
    opb_w = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        opa_w = bus.opa[i*WIDTH +: WIDTH];
        opb_w = bus.opb[i*WIDTH +: WIDTH];
      end
    end
  end

  // Sum bits enter at the MSB of A so after WIDTH shifts A holds the result.
  assign sum      = {1'b0, a_sh[0]} + {1'b0, b_sh[0]} + {1'b0, carry};
  assign a_nxt    = {sum[0], a_sh[WIDTH-1:1]};
  assign last_bit = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      count     <= '0;
      last      <= IDW'(NREQ - 1);
      gnt_q     <= '0;
      done_id_q <= '0;
      result_q  <= '0;
    end else begin
      gnt_q <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            a_sh  <= opa_w;
            b_sh  <= opb_w;
            carry <= 1'b0;
            count <= '0;
            last  <= win;
            gnt_q <= NREQ'(1) << win;
          end
        end
        SHIFT: begin
          a_sh  <= a_nxt;
          b_sh  <= b_sh >> 1;
          carry <= sum[1];
          count <= count + 1'b1;
          if (last_bit) begin
            result_q  <= a_nxt;
            done_id_q <= last;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADD_CARRY_EN
  logic cout_q;

  always_ff @(posedge clk) begin
    if (rst)                             cout_q <= 1'b0;
    else if (state == SHIFT && last_bit) cout_q <= sum[1];
  end

  assign bus.cout = cout_q;
`else
  assign bus.cout = 1'b0;
`endif

  assign bus.gnt     = gnt_q;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.done_id = done_id_q;
  assign bus.result  = result_q;
endmodule

// File: tb/tb_serial_add_scheduler.sv
module tb_serial_add_scheduler;
  localparam int W = 23;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_add_scheduler_if #(.WIDTH(W), .NREQ(N)) bus();
  serial_add_scheduler #(.WIDTH(W), .NREQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int rr_last = N - 1;  // model of the round-robin pointer
  logic [W-1:0] va [N];
  logic [W-1:0] vb [N];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops;
    for (int i = 0; i < N; i++) begin
      bus.opa[i*W +: W] = va[i];
      bus.opb[i*W +: W] = vb[i];
    end
  endtask

  task automatic rand_ops;
    for (int i = 0; i < N; i++) begin
      va[i] = W'($urandom);
      vb[i] = W'($urandom);
    end
    set_ops();
  endtask

  // Ticks until gnt appears; cyc=-1 on timeout. idle counts busy-low samples.
  task automatic wait_gnt(output int cyc, output int idle);
    cyc  = -1;
    idle = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bus.gnt != '0) begin cyc = i; break; end
      if (!bus.busy) idle++;
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bus.done) begin cyc = i; break; end
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [W:0] add_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic cout_ref(input logic [W:0] s);
`ifdef SERIAL_ADD_CARRY_EN
    return s[W];
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    rr_last = N - 1;
  endtask

  task automatic test_reset;
    bus.req = '0;
    for (int i = 0; i < N; i++) begin va[i] = '0; vb[i] = '0; end
    set_ops();
    do_reset();
    n_total++; if (bus.gnt !== 4'b0000) $display("FAIL rst_gnt got=%b exp=0000", bus.gnt); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", bus.busy); else n_pass++;
    n_total++; if (bus.done !== 1'b0) $display("FAIL rst_done got=%b exp=0", bus.done); else n_pass++;
    n_total++; if (bus.done_id !== 2'd0) $display("FAIL rst_done_id got=%0d exp=0", bus.done_id); else n_pass++;
    n_total++; if (bus.result !== 23'd0) $display("FAIL rst_result got=%0d exp=0", bus.result); else n_pass++;
    n_total++; if (bus.cout !== 1'b0) $display("FAIL rst_cout got=%b exp=0", bus.cout); else n_pass++;
  endtask

  // Single requester adds, including the wrap case.
  task automatic test_basic;
    int           tid [3] = '{0, 1, 1};
    logic [W-1:0] ta  [3] = '{23'd1, 23'd12, 23'h7FFFFF};
    logic [W-1:0] tb  [3] = '{23'd12, 23'd14, 23'd1};
    int cyc, idle;
    logic [W:0] s;
    logic [N-1:0] eg;
    for (int t = 0; t < 3; t++) begin
      va[tid[t]] = ta[t];
      vb[tid[t]] = tb[t];
      set_ops();
      bus.req = '0;
      bus.req[tid[t]] = 1'b1;
      eg = '0;
      eg[pick(bus.req, rr_last)] = 1'b1;
      s = add_ref(ta[t], tb[t]);
      wait_gnt(cyc, idle);
      n_total++; if (cyc !== 1) $display("FAIL basic%0d_gnt_lat got=%0d exp=1", t, cyc); else n_pass++;
      n_total++; if (bus.gnt !== eg) $display("FAIL basic%0d_gnt got=%b exp=%b", t, bus.gnt, eg); else n_pass++;
      n_total++; if (bus.busy !== 1'b1) $display("FAIL basic%0d_busy got=%b exp=1", t, bus.busy); else n_pass++;
      rr_last = tid[t];
      bus.req = '0;
      tick();
      n_total++; if (bus.gnt !== 4'b0000) $display("FAIL basic%0d_gnt_1cyc got=%b exp=0000", t, bus.gnt); else n_pass++;
      wait_done(cyc);
      n_total++; if (cyc + 1 !== W) $display("FAIL basic%0d_done_lat got=%0d exp=%0d", t, cyc + 1, W); else n_pass++;
      n_total++; if (bus.result !== s[W-1:0]) $display("FAIL basic%0d_result got=%0d exp=%0d", t, bus.result, s[W-1:0]); else n_pass++;
      n_total++; if (bus.done_id !== 2'(tid[t])) $display("FAIL basic%0d_done_id got=%0d exp=%0d", t, bus.done_id, tid[t]); else n_pass++;
      n_total++; if (bus.cout !== cout_ref(s)) $display("FAIL basic%0d_cout got=%b exp=%b", t, bus.cout, cout_ref(s)); else n_pass++;
      tick();
      n_total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) $display("FAIL basic%0d_after got=%b%b exp=00", t, bus.done, bus.busy); else n_pass++;
    end
  endtask

  // Held requests served in round-robin order with fixed op spacing.
  task automatic test_rr(input logic [N-1:0] r, input int nops, input string nm);
    int cyc, idle, e;
    logic [W:0] s;
    logic [N-1:0] eg;
    do_reset();
    rand_ops();
    bus.req = r;
    for (int k = 0; k < nops; k++) begin
      wait_gnt(cyc, idle);
      e = pick(r, rr_last);
      eg = '0;
      eg[e] = 1'b1;
      if (k > 0) begin
        n_total++; if (cyc !== 2) $display("FAIL %s%0d_gap got=%0d exp=2", nm, k, cyc); else n_pass++;
        n_total++; if (idle !== 1) $display("FAIL %s%0d_idle got=%0d exp=1", nm, k, idle); else n_pass++;
      end
      n_total++; if (bus.gnt !== eg) $display("FAIL %s%0d_gnt got=%b exp=%b", nm, k, bus.gnt, eg); else n_pass++;
      rr_last = e;
      s = add_ref(va[e], vb[e]);
      wait_done(cyc);
      n_total++; if (cyc !== W) $display("FAIL %s%0d_lat got=%0d exp=%0d", nm, k, cyc, W); else n_pass++;
      n_total++; if (bus.done_id !== 2'(e)) $display("FAIL %s%0d_done_id got=%0d exp=%0d", nm, k, bus.done_id, e); else n_pass++;
      n_total++; if (bus.result !== s[W-1:0]) $display("FAIL %s%0d_result got=%0d exp=%0d", nm, k, bus.result, s[W-1:0]); else n_pass++;
    end
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_mid_reset;
    int cyc, idle;
    logic [W:0] s;
    va[3] = 23'd100;
    vb[3] = 23'd200;
    set_ops();
    bus.req = 4'b1000;
    wait_gnt(cyc, idle);
    n_total++; if (bus.gnt !== 4'b1000) $display("FAIL mrst_gnt3 got=%b exp=1000", bus.gnt); else n_pass++;
    bus.req = '0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rr_last = N - 1;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL mrst_busy got=%b exp=0", bus.busy); else n_pass++;
    n_total++; if (bus.result !== 23'd0) $display("FAIL mrst_result got=%0d exp=0", bus.result); else n_pass++;
    n_total++; if (bus.done !== 1'b0) $display("FAIL mrst_done got=%b exp=0", bus.done); else n_pass++;
    va[3] = 23'd5;
    vb[3] = 23'd7;
    va[0] = W'($urandom);
    vb[0] = W'($urandom);
    set_ops();
    bus.req = 4'b1001;
    wait_gnt(cyc, idle);
    n_total++; if (bus.gnt !== 4'b0001) $display("FAIL mrst_gnt0 got=%b exp=0001", bus.gnt); else n_pass++;
    bus.req = 4'b1000;
    s = add_ref(va[0], vb[0]);
    wait_done(cyc);
    n_total++; if (bus.result !== s[W-1:0]) $display("FAIL mrst_result0 got=%0d exp=%0d", bus.result, s[W-1:0]); else n_pass++;
    wait_gnt(cyc, idle);
    n_total++; if (bus.gnt !== 4'b1000) $display("FAIL mrst_gnt3b got=%b exp=1000", bus.gnt); else n_pass++;
    bus.req = '0;
    wait_done(cyc);
    n_total++; if (bus.result !== 23'd12) $display("FAIL mrst_result3 got=%0d exp=12", bus.result); else n_pass++;
    n_total++; if (bus.done_id !== 2'd3) $display("FAIL mrst_done_id got=%0d exp=3", bus.done_id); else n_pass++;
    rr_last = 3;
    tick();
  endtask

  // Operand changes after the grant edge must not affect the sum.
  task automatic test_operand_change;
    int cyc, idle;
    logic [W:0] s;
    va[2] = W'($urandom);
    vb[2] = W'($urandom);
    set_ops();
    bus.req = 4'b0100;
    wait_gnt(cyc, idle);
    n_total++; if (bus.gnt !== 4'b0100) $display("FAIL opchg_gnt got=%b exp=0100", bus.gnt); else n_pass++;
    rr_last = 2;
    bus.req = '0;
    s = add_ref(va[2], vb[2]);
    cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      rand_ops();
      tick();
      if (bus.done) begin cyc = i; break; end
    end
    n_total++; if (cyc !== W) $display("FAIL opchg_lat got=%0d exp=%0d", cyc, W); else n_pass++;
    n_total++; if (bus.result !== s[W-1:0]) $display("FAIL opchg_result got=%0d exp=%0d", bus.result, s[W-1:0]); else n_pass++;
    tick();
  endtask

  // Random request sets and operands against the arbitration/sum model.
  task automatic test_random;
    int cyc, idle, e;
    logic [N-1:0] r;
    logic [N-1:0] eg;
    logic [W:0] s;
    for (int it = 0; it < 25; it++) begin
      r = N'($urandom_range(1, 15));
      bus.req = r;
      rand_ops();
      wait_gnt(cyc, idle);
      e = pick(r, rr_last);
      eg = '0;
      eg[e] = 1'b1;
      n_total++; if (bus.gnt !== eg) $display("FAIL rnd%0d_gnt got=%b exp=%b", it, bus.gnt, eg); else n_pass++;
      rr_last = e;
      s = add_ref(va[e], vb[e]);
      repeat (5) tick();
      rand_ops();
      bus.req = N'($urandom_range(0, 15));
      wait_done(cyc);
      n_total++; if (cyc !== W - 5) $display("FAIL rnd%0d_lat got=%0d exp=%0d", it, cyc, W - 5); else n_pass++;
      n_total++; if (bus.result !== s[W-1:0]) $display("FAIL rnd%0d_result got=%0d exp=%0d", it, bus.result, s[W-1:0]); else n_pass++;
      n_total++; if (bus.done_id !== 2'(e)) $display("FAIL rnd%0d_done_id got=%0d exp=%0d", it, bus.done_id, e); else n_pass++;
      n_total++; if (bus.cout !== cout_ref(s)) $display("FAIL rnd%0d_cout got=%b exp=%b", it, bus.cout, cout_ref(s)); else n_pass++;
    end
    bus.req = '0;
    tick();
    tick();
  endtask

  initial begin
    bus.req = '0;
    bus.opa = '0;
    bus.opb = '0;
    test_reset();
    test_basic();
    test_rr(4'b0101, 4, "pair");
    test_rr(4'b1111, 5, "all");
    test_mid_reset();
    test_operand_change();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
